// File: rtl/astro_pkg.sv
// rtl/astro_pkg.sv - shared state encodings and lane geometry for the barrier game
package astro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10,
        ST_LOSE = 2'b11
    } state_t;

    localparam int COORD_W_DEF = 10;

    function automatic int lane_top(input int i, input int y0 = 64, input int pitch = 64);
        return y0 + i * pitch;
    endfunction

endpackage

// File: rtl/astro_target.sv
// rtl/astro_target.sv - one bouncing target lane: position, direction, hit flag, hit and pixel compare
module astro_target
    import astro_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int IDX     = 0,
    parameter int XL      = 60,
    parameter int XR      = 580,
    parameter int HALF    = 10,
    parameter int H       = 16,
    parameter int Y0      = 64,
    parameter int PITCH   = 64,
    parameter int SPEED   = 1
) (
    input  logic               clk,
    input  logic               reset_bar,
    input  logic               load_i,
    input  logic               adv_i,
    input  logic               hit_set_i,
    input  logic               shot_act_i,
    input  logic [COORD_W-1:0] shot_x_i,
    input  logic [COORD_W-1:0] shot_y_i,
    input  logic [COORD_W-1:0] counter_x_i,
    input  logic [COORD_W-1:0] counter_y_i,
    output logic               hit_o,
    output logic               match_o,
    output logic               pix_o
);
    typedef logic [COORD_W:0] cext_t;

    localparam cext_t TOP    = cext_t'(lane_top(IDX, Y0, PITCH));
    localparam cext_t BOT    = cext_t'(lane_top(IDX, Y0, PITCH) + H - 1);
    localparam cext_t HALF_W = cext_t'(HALF);

    logic [COORD_W-1:0] x_q;
    logic               dir_q;  // 1 = moving left
    logic               hit_q;
    cext_t              x_w;

    assign x_w   = {1'b0, x_q};
    assign hit_o = hit_q;

    always_ff @(posedge clk) begin
        if (!reset_bar || load_i) begin
            x_q   <= COORD_W'(XL + 64 * IDX);
            dir_q <= 1'b0;
            hit_q <= 1'b0;
        end else if (hit_set_i) begin
            hit_q <= 1'b1;
        end else if (adv_i && !hit_q) begin
            // Landing exactly on a bound counts as a bounce, so the next step already reverses.
            if (!dir_q) begin
                if (x_w + cext_t'(SPEED) >= cext_t'(XR)) begin
                    x_q   <= COORD_W'(XR);
                    dir_q <= 1'b1;
                end else begin
                    x_q <= x_q + COORD_W'(SPEED);
                end
            end else begin
                if (x_w <= cext_t'(XL + SPEED)) begin
                    x_q   <= COORD_W'(XL);
                    dir_q <= 1'b0;
                end else begin
                    x_q <= x_q - COORD_W'(SPEED);
                end
            end
        end
    end

    assign match_o = !hit_q && shot_act_i
                  && ({1'b0, shot_x_i} + HALF_W >= x_w) && ({1'b0, shot_x_i} <= x_w + HALF_W)
                  && ({1'b0, shot_y_i} >= TOP) && ({1'b0, shot_y_i} <= BOT);

    assign pix_o = !hit_q
                && ({1'b0, counter_x_i} + HALF_W >= x_w) && ({1'b0, counter_x_i} <= x_w + HALF_W)
                && ({1'b0, counter_y_i} >= TOP) && ({1'b0, counter_y_i} <= BOT);

endmodule

// File: rtl/astro_barrier_engine.sv
// rtl/astro_barrier_engine.sv - barrier game core: ship, single shot, target lanes, game FSM and pixel colour
module astro_barrier_engine
    import astro_pkg::*;
#(
    parameter int NUM_TARGETS = 4,
    parameter int COORD_W     = COORD_W_DEF,
    parameter int X_MIN       = 30,
    parameter int X_MAX       = 610,
    parameter int SHIP_STEP   = 2,
    parameter int SHIP_HALF   = 30,
    parameter int SHIP_ROW    = 7,
    parameter int SHOT_Y0     = 440,
    parameter int SHOT_STEP   = 10,
    parameter int SHOT_HALF   = 10,
    parameter int SHOT_LIMIT  = 8,
    parameter int TGT_XL      = 60,
    parameter int TGT_XR      = 580,
    parameter int TGT_HALF    = 10,
    parameter int TGT_H       = 16,
    parameter int LANE_Y0     = 64,
    parameter int LANE_PITCH  = 64,
    parameter int TGT_SPEED   = 1
) (
    input  logic                   clk,
    input  logic                   reset_bar,
    input  logic                   tick,
    input  logic                   start,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_fire,
    input  logic [COORD_W-1:0]     counter_x,
    input  logic [COORD_W-1:0]     counter_y,
    input  logic                   in_display,
    output logic                   vga_r,
    output logic                   vga_g,
    output logic                   vga_b,
    output logic [1:0]             state,
    output logic [3:0]             score,
    output logic [3:0]             shots_left,
    output logic [NUM_TARGETS-1:0] hit_mask,
    output logic [COORD_W-1:0]     ship_x
);
    typedef logic [COORD_W:0] cext_t;

    state_t             state_q;
    logic [COORD_W-1:0] ship_x_q, ship_x_d, shot_x_q, shot_x_d, shot_y_q, shot_y_d;
    logic               shot_act_q, shot_act_d;
    logic [3:0]         score_q, score_d, shots_q, shots_d;
    logic [NUM_TARGETS-1:0] hit_q, match, hit_sel, pix_g, hit_mask_d;
    logic               vga_r_q, vga_g_q, vga_b_q;
    logic               play_tick, load, any_hit, ship_pix, shot_pix;
    cext_t              ship_w, cx_w, cy_w, sx_w, sy_w;

    assign play_tick = tick && start && (state_q == ST_PLAY);
    assign load      = tick && !start;
    assign ship_w    = {1'b0, ship_x_q};
    assign cx_w      = {1'b0, counter_x};
    assign cy_w      = {1'b0, counter_y};
    assign sx_w      = {1'b0, shot_x_q};
    assign sy_w      = {1'b0, shot_y_q};

    for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_tgt
        astro_target #(
            .COORD_W(COORD_W), .IDX(i), .XL(TGT_XL), .XR(TGT_XR), .HALF(TGT_HALF), .H(TGT_H),
            .Y0(LANE_Y0), .PITCH(LANE_PITCH), .SPEED(TGT_SPEED * (i + 1))
        ) u_tgt (
            .clk(clk), .reset_bar(reset_bar), .load_i(load), .adv_i(play_tick),
            .hit_set_i(play_tick && hit_sel[i]), .shot_act_i(shot_act_q),
            .shot_x_i(shot_x_q), .shot_y_i(shot_y_q), .counter_x_i(counter_x), .counter_y_i(counter_y),
            .hit_o(hit_q[i]), .match_o(match[i]), .pix_o(pix_g[i])
        );
    end

    always_comb begin : p_hit_sel
        logic found;
        found   = 1'b0;
        hit_sel = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (match[i] && !found) begin
                hit_sel[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_hit    = |hit_sel;
    assign hit_mask_d = hit_q | hit_sel;
    assign score_d    = score_q + {3'b000, any_hit};

    always_comb begin
        ship_x_d = ship_x_q;
        if (btn_right && !btn_left) begin
            if (ship_w + cext_t'(SHIP_STEP) >= cext_t'(X_MAX)) ship_x_d = COORD_W'(X_MAX);
            else                                               ship_x_d = ship_x_q + COORD_W'(SHIP_STEP);
        end else if (btn_left && !btn_right) begin
            if (ship_w <= cext_t'(X_MIN + SHIP_STEP)) ship_x_d = COORD_W'(X_MIN);
            else                                      ship_x_d = ship_x_q - COORD_W'(SHIP_STEP);
        end
    end

    // Fire only from an idle shot, so launch and flight never compete for the shot registers.
    always_comb begin
        shot_act_d = shot_act_q;
        shot_x_d   = shot_x_q;
        shot_y_d   = shot_y_q;
        shots_d    = shots_q;
        if (shot_act_q) begin
            if (any_hit || shot_y_q < COORD_W'(SHOT_STEP)) shot_act_d = 1'b0;
            else                                           shot_y_d   = shot_y_q - COORD_W'(SHOT_STEP);
        end else if (btn_fire && shots_q != 4'd0) begin
            shot_act_d = 1'b1;
            shot_x_d   = ship_x_q;
            shot_y_d   = COORD_W'(SHOT_Y0);
            shots_d    = shots_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_bar || load) begin
            state_q    <= ST_IDLE;
            ship_x_q   <= COORD_W'((X_MIN + X_MAX) / 2);
            shot_act_q <= 1'b0;
            shot_x_q   <= '0;
            shot_y_q   <= '0;
            score_q    <= 4'd0;
            shots_q    <= 4'(SHOT_LIMIT);
        end else if (tick) begin
            case (state_q)
                ST_IDLE: state_q <= ST_PLAY;
                ST_PLAY: begin
                    ship_x_q   <= ship_x_d;
                    shot_act_q <= shot_act_d;
                    shot_x_q   <= shot_x_d;
                    shot_y_q   <= shot_y_d;
                    score_q    <= score_d;
                    shots_q    <= shots_d;
                    if (&hit_mask_d)                        state_q <= ST_WIN;
                    else if (shots_d == 4'd0 && !shot_act_d) state_q <= ST_LOSE;
                end
                default: ;
            endcase
        end
    end

    assign ship_pix = (cx_w + cext_t'(SHIP_HALF) >= ship_w) && (cx_w <= ship_w + cext_t'(SHIP_HALF))
                   && (counter_y[9:6] == 4'(SHIP_ROW));
    assign shot_pix = shot_act_q
                   && (cx_w + cext_t'(SHOT_HALF) >= sx_w) && (cx_w <= sx_w + cext_t'(SHOT_HALF))
                   && (cy_w + cext_t'(SHOT_HALF) >= sy_w) && (cy_w <= sy_w + cext_t'(SHOT_HALF));

    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            vga_r_q <= 1'b0;
            vga_g_q <= 1'b0;
            vga_b_q <= 1'b0;
        end else begin
            vga_r_q <= in_display && ship_pix;
            vga_g_q <= in_display && (|pix_g);
            vga_b_q <= in_display && shot_pix;
        end
    end

    assign vga_r      = vga_r_q;
    assign vga_g      = vga_g_q;
    assign vga_b      = vga_b_q;
    assign state      = state_q;
    assign score      = score_q;
    assign shots_left = shots_q;
    assign hit_mask   = hit_q;
    assign ship_x     = ship_x_q;

endmodule

// File: tb/tb_astro_barrier_engine.sv
// tb/tb_astro_barrier_engine.sv - directed self-checking bench for astro_barrier_engine
module tb_astro_barrier_engine;
    logic       clk = 1'b0;
    logic       reset_bar, tick, start, btn_left, btn_right, btn_fire, in_display;
    logic [9:0] counter_x, counter_y;
    logic       vga_r, vga_g, vga_b;
    logic [1:0] state;
    logic [3:0] score, shots_left, hit_mask;
    logic [9:0] ship_x;
    logic [2:0] pix;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    astro_barrier_engine dut (
        .clk(clk), .reset_bar(reset_bar), .tick(tick), .start(start),
        .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
        .counter_x(counter_x), .counter_y(counter_y), .in_display(in_display),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .state(state), .score(score),
        .shots_left(shots_left), .hit_mask(hit_mask), .ship_x(ship_x)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            @(posedge clk);
            #1;
            tick = 1'b0;
        end
    endtask

    task automatic probe(input int x, input int y, output logic [2:0] rgb);
        counter_x  = 10'(x);
        counter_y  = 10'(y);
        in_display = 1'b1;
        @(posedge clk);
        #1;
        rgb        = {vga_r, vga_g, vga_b};
        in_display = 1'b0;
    endtask

    // Target centre is pinned by the green box edges at x-10 and x+10.
    task automatic check_tgt(input int i, input int x);
        logic [2:0] p;
        int y;
        y = 64 + 64 * i;
        probe(x - 11, y, p); check($sformatf("tgt%0d_x%0d_lo_out", i, x), p[1], 0);
        probe(x - 10, y, p); check($sformatf("tgt%0d_x%0d_lo_in", i, x), p[1], 1);
        probe(x + 10, y, p); check($sformatf("tgt%0d_x%0d_hi_in", i, x), p[1], 1);
        probe(x + 11, y, p); check($sformatf("tgt%0d_x%0d_hi_out", i, x), p[1], 0);
    endtask

    task automatic check_idle_values(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_ship"}, ship_x, 320);
        check({tag, "_shots"}, shots_left, 8);
        check({tag, "_score"}, score, 0);
        check({tag, "_hits"}, hit_mask, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset_bar = 0; tick = 0; start = 0; btn_left = 0; btn_right = 0; btn_fire = 0;
        counter_x = 0; counter_y = 0; in_display = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_bar = 1;
        check_idle_values("por");
        check("por_vga", {vga_r, vga_g, vga_b}, 0);

        start = 1; run_ticks(1);
        check("enter_play", state, 1);
        btn_right = 1; run_ticks(3); btn_right = 0;
        check("pre_reset_ship", ship_x, 326);
        btn_fire = 1; run_ticks(1); btn_fire = 0;
        check("pre_reset_shots", shots_left, 7);

        // Reset mid-game with tick, buttons and a lit ship pixel all active.
        reset_bar = 0; tick = 1; btn_right = 1; btn_fire = 1;
        counter_x = 320; counter_y = 460; in_display = 1;
        repeat (2) @(posedge clk);
        #1;
        reset_bar = 1; tick = 0; btn_right = 0; btn_fire = 0; in_display = 0;
        check_idle_values("rst");
        check("rst_vga", {vga_r, vga_g, vga_b}, 0);
        @(posedge clk); #1;
        check_tgt(0, 60); check_tgt(1, 124); check_tgt(2, 188); check_tgt(3, 252);

        counter_x = 320; counter_y = 460; in_display = 1;
        check("rend_before_edge", vga_r, 0);
        @(posedge clk); #1;
        check("rend_ship_rgb", {vga_r, vga_g, vga_b}, 3'b100);
        in_display = 0;
        @(posedge clk); #1;
        check("rend_blank_rgb", {vga_r, vga_g, vga_b}, 0);
        probe(350, 460, pix); check("rend_ship_xr_in", pix[2], 1);
        probe(351, 460, pix); check("rend_ship_xr_out", pix[2], 0);
        probe(320, 448, pix); check("rend_ship_row_in", pix[2], 1);
        probe(320, 447, pix); check("rend_ship_row_out", pix[2], 0);

        run_ticks(1);
        check("move_play", state, 1);
        btn_right = 1;
        for (int n = 1; n <= 150; n++) begin
            run_ticks(1);
            case (n)
                1:   check("move_r1", ship_x, 322);
                145: check("move_r145", ship_x, 610);
                150: check("move_sat", ship_x, 610);
                default: ;
            endcase
        end
        btn_left = 1; run_ticks(1);
        check("move_both", ship_x, 610);
        btn_right = 0;
        @(posedge clk); #1;
        check("move_no_tick", ship_x, 610);
        run_ticks(1);
        check("move_left", ship_x, 608);
        btn_left = 0;

        start = 0; run_ticks(1);
        check("abort_state", state, 0);
        check("abort_ship", ship_x, 320);
        start = 1; run_ticks(1);
        run_ticks(82);  check_tgt(3, 580);
        run_ticks(1);   check_tgt(3, 576); check_tgt(0, 143);
        run_ticks(437); check_tgt(0, 580); check_tgt(3, 252);
        run_ticks(1);   check_tgt(0, 579);

        // Timed game: shots hit lanes 3,2,1 from x=320, four wasted shots at x=30, last shot hits lane 0.
        start = 0; run_ticks(1);
        start = 1; run_ticks(1);
        for (int n = 1; n <= 778; n++) begin
            btn_fire  = (n == 1 || n == 2 || n == 20 || n == 65 || n == 242 || n == 288 ||
                         n == 334 || n == 380 || n == 740);
            btn_left  = (n >= 97 && n <= 241);
            btn_right = (n >= 426 && n <= 570);
            run_ticks(1);
            case (n)
                1:   check("hit_fire1_shots", shots_left, 7);
                2:   check("hit_refire_shots", shots_left, 7);
                18: begin
                    check("hit_pre_mask", hit_mask, 0);
                    probe(320, 270, pix); check("hit_pre_shot_b", pix[0], 1);
                end
                19: begin
                    check("hit3_mask", hit_mask, 4'b1000);
                    check("hit3_score", score, 1);
                    probe(320, 270, pix); check("hit3_shot_cleared", pix[0], 0);
                    probe(324, 264, pix); check("hit3_not_drawn", pix[1], 0);
                end
                45: begin
                    check("hit2_mask", hit_mask, 4'b1100);
                    check("hit2_score", score, 2);
                end
                96: begin
                    check("hit1_mask", hit_mask, 4'b1110);
                    probe(324, 264, pix); check("hit3_still_hidden", pix[1], 0);
                end
                241: check("win_ship_left", ship_x, 30);
                425: begin
                    check("win_mid_state", state, 1);
                    check("win_mid_shots", shots_left, 1);
                end
                570: check("win_ship_back", ship_x, 320);
                777: begin
                    check("win_pre_state", state, 1);
                    check("win_pre_shots", shots_left, 0);
                end
                778: begin
                    check("win_state", state, 2);
                    check("win_mask", hit_mask, 4'b1111);
                    check("win_score", score, 4);
                end
                default: ;
            endcase
        end
        btn_fire = 1; btn_right = 1; run_ticks(1);
        check("win_frozen_state", state, 2);
        check("win_frozen_ship", ship_x, 320);
        btn_fire = 0; btn_right = 0;
        start = 0; run_ticks(1);
        check_idle_values("win_exit");

        start = 1; run_ticks(1);
        for (int n = 1; n <= 513; n++) begin
            btn_left = (n <= 145);
            btn_fire = (n >= 146);
            run_ticks(1);
            case (n)
                145: check("lose_ship", ship_x, 30);
                146: check("lose_fire1", shots_left, 7);
                512: begin
                    check("lose_pre_state", state, 1);
                    check("lose_pre_shots", shots_left, 0);
                end
                513: check("lose_state", state, 3);
                default: ;
            endcase
        end
        run_ticks(1);
        check("lose_frozen_state", state, 3);
        check("lose_frozen_shots", shots_left, 0);
        btn_fire = 0; btn_left = 0;
        start = 0; run_ticks(1);
        check_idle_values("lose_exit");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/astro_barrier_engine.md
Name: astro_barrier_engine

Overview:
- Parametrised game core for the VGA barrier game.
- Contains one player cannon, NUM_TARGETS bouncing targets in separate horizontal lanes, and a single shot with a per-level ammo limit.
- Tracks hits, score and a win/lose state machine, and generates registered RGB pixel bits from the sync generator's counters.
- Sits between the hvsync generator, the debounced buttons/switches, and the LED/SSD status logic.

Parameters:
- NUM_TARGETS, 4: number of target lanes (1..8).
- COORD_W, 10: coordinate width.
- X_MIN, 30: minimum ship centre x.
- X_MAX, 610: maximum ship centre x.
- SHIP_STEP, 2: ship pixels moved per tick.
- SHIP_HALF, 30: ship half-width.
- SHIP_ROW, 7: ship drawn where counter_y[9:6]==SHIP_ROW.
- SHOT_Y0, 440: shot launch y.
- SHOT_STEP, 10: shot rise per tick; must be ≤ TGT_H.
- SHOT_HALF, 10: shot half-size.
- SHOT_LIMIT, 8: shots per game.
- TGT_XL, 60: left bounce bound for target centres.
- TGT_XR, 580: right bounce bound for target centres.
- TGT_HALF, 10: target half-width.
- TGT_H, 16: lane height.
- LANE_Y0, 64: top row of lane 0.
- LANE_PITCH, 64: row spacing between lanes.
- TGT_SPEED, 1: base speed; target i moves TGT_SPEED*(i+1) per tick.

Ports:
- clk  in  1  system clock.
- reset_bar  in  1  synchronous active-low reset.
- tick  in  1  one-cycle game-update enable (frame rate).
- start  in  1  game-enable switch level.
- btn_left, btn_right, btn_fire  in  1 each  debounced buttons.
- counter_x, counter_y  in  COORD_W each  pixel position.
- in_display  in  1  visible-area flag.
- vga_r, vga_g, vga_b  out  1 each  registered colour bits.
- state  out  2  game state.
- score  out  4  targets hit.
- shots_left  out  4  remaining ammo.
- hit_mask  out  NUM_TARGETS  per-target hit flag.
- ship_x  out  COORD_W  ship centre x.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: reset_bar sampled low at a clk edge takes effect at that edge, and has priority over tick.
- Reset values:
  - state=IDLE(00), ship_x=(X_MIN+X_MAX)/2=320, score=0, shots_left=SHOT_LIMIT, hit_mask=0.
  - shot inactive, vga_r/g/b=0.
  - target i: x=TGT_XL+64*i, direction right.
- The same initial values are loaded on every entry to IDLE.
- States: IDLE=00, PLAY=01, WIN=10, LOSE=11. All game updates and transitions occur only on cycles with tick=1.
  - IDLE -> PLAY when start=1.
  - PLAY -> IDLE when start=0 (abort).
  - PLAY -> WIN when hit_mask becomes all ones.
  - PLAY -> LOSE when shots_left==0, no shot is active, and hit_mask is not all ones, all evaluated after this tick's updates. WIN has priority when both apply on the same tick.
  - WIN/LOSE: everything frozen; -> IDLE when start=0.
- PLAY tick, all evaluated on pre-tick values:
  - Ship: moves only if exactly one of left/right is asserted; moves ±SHIP_STEP, saturating exactly at X_MIN/X_MAX. Both or neither pressed: no move.
  - Fire: if btn_fire && !shot_active && shots_left>0, then shot_active=1, shot_x=pre-move ship_x, shot_y=SHOT_Y0, and shots_left decrements. Fire is independent of movement. Fire while a shot is active is ignored and does not consume ammo.
  - Shot flight: if active and shot_y<SHOT_STEP, the shot deactivates (miss); otherwise shot_y-=SHOT_STEP.
  - Hit test: for each unhit target i, a hit occurs when shot_x+TGT_HALF ≥ tgt_x[i], shot_x ≤ tgt_x[i]+TGT_HALF, and shot_y lies in [LANE_Y0+i*LANE_PITCH, that row+TGT_H-1].
    - The lowest-index match wins; at most one hit per tick.
    - On a hit: hit_mask[i]=1, score+1, and the shot deactivates on the same tick.
  - Targets: each unhit target moves by its speed. If the next position would pass its bound, it is set to the bound and its direction flips. A hit target freezes.
- Arithmetic: all coordinate compares are done in COORD_W+1 bits in add-form (a+h ≥ b) so nothing underflows.
- Rendering, with 1-cycle latency from counter_x/counter_y/in_display to vga_*:
  - R = ship: |counter_x−ship_x| ≤ SHIP_HALF and the row matches SHIP_ROW.
  - G = any unhit target box (lane rows, ±TGT_HALF).
  - B = active shot box (±SHOT_HALF in both axes).
  - Overlapping objects OR their colours. All outputs are 0 when in_display=0.
  - Hit targets are not drawn.

Decomposition:
- Package astro_pkg holds:
  - state encodings (IDLE/PLAY/WIN/LOSE, matching the LED state mapping);
  - the COORD_W default;
  - a lane_top(i) constant function.
- Sub-module astro_target: one lane's x, direction and hit flag, with bounce logic and hit compare. Instantiated NUM_TARGETS times via generate; the engine priority-selects the lowest-index hit.

Test Plan:
1. Reset: reset_bar low 2 cycles mid-PLAY -> state=00, ship_x=320, shots_left=8, score=0, hit_mask=0, target x = 60/124/188/252, vga=000.
2. Movement: PLAY, btn_right held 150 ticks -> ship_x rises 2/tick and saturates at 610. Both buttons held -> ship_x unchanged. tick=0 with buttons held -> no change.
3. Bounce: target 0 (speed 1) runs 60→580 in 520 ticks, then 579 on the next tick. Target 3 (speed 4) from 252 reaches 580 exactly and reverses.
4. Hit: fire with timing computed so target 3 is within ±10 of shot_x when shot_y=270 -> hit_mask=1000, score=1, shot cleared that tick, target 3 frozen and G never asserted at its box. A second fire while a shot is active -> shots_left unchanged.
5. Lose/win: ship at x=30, 8 shots fired -> after the last shot exits, state=11 and further fire is ignored; start=0 -> state=00 on the next tick. Separately, the last unhit target hit by the final shot -> state=10, not 11.
6. Render: counter (320, 460) with in_display=1 at reset ship position -> vga_r=1 exactly one clk later. Same coordinates with in_display=0 -> 000.
